// File: rtl/rbcp_pkg.sv
// Shared definitions for the local register bus master.
//   rbcp_state_e    : burst FSM states
//   LOC_AW / LOC_DW : local bus address / data widths
//   LEN_W           : burst length field width (byte count minus 1)
//   ACK_TIMEOUT_DEF : default cycles to wait for LOC_ACK before aborting
package rbcp_pkg;

  localparam int LOC_AW          = 32;
  localparam int LOC_DW          = 8;
  localparam int LEN_W           = 8;
  localparam int ACK_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } rbcp_state_e;

endpackage

// File: rtl/rbcp_loc_master_if.sv
// Bundle of the command, write-data, read-data, status and local bus
// signals of rbcp_loc_master.
//   master modport : the burst master (drives LOC_* strobes, CMD_READY, ...)
//   slave  modport : everything around it (command source, WD source,
//                    RD sink and the register-file responder)
interface rbcp_loc_master_if;
  import rbcp_pkg::*;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_WR;
  logic [LOC_AW-1:0] CMD_ADDR;
  logic [LEN_W-1:0]  CMD_LEN;
  logic              WD_VALID;
  logic              WD_READY;
  logic [LOC_DW-1:0] WD_DATA;
  logic              RD_VALID;
  logic [LOC_DW-1:0] RD_DATA;
  logic              DONE;
  logic              ERR;
  logic [LOC_AW-1:0] LOC_ADDR;
  logic              LOC_WE;
  logic [LOC_DW-1:0] LOC_WD;
  logic              LOC_RE;
  logic              LOC_ACK;
  logic [LOC_DW-1:0] LOC_RD;

  modport master (
    input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_LEN, WD_VALID, WD_DATA,
           LOC_ACK, LOC_RD,
    output CMD_READY, WD_READY, RD_VALID, RD_DATA, DONE, ERR,
           LOC_ADDR, LOC_WE, LOC_WD, LOC_RE
  );

  modport slave (
    output CMD_VALID, CMD_WR, CMD_ADDR, CMD_LEN, WD_VALID, WD_DATA,
           LOC_ACK, LOC_RD,
    input  CMD_READY, WD_READY, RD_VALID, RD_DATA, DONE, ERR,
           LOC_ADDR, LOC_WE, LOC_WD, LOC_RE
  );

endinterface

// File: rtl/rbcp_loc_master_ack_timer.sv
// rbcp_ack_timer: acknowledge watchdog for one outstanding bus access.
//   CLK, RSTn : clock, asynchronous active-low reset
//   clr       : restart the count (asserted in the strobe cycle)
//   en        : count one cycle of waiting for LOC_ACK
//   expired   : ACK_TIMEOUT cycles have elapsed since the strobe
module rbcp_ack_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt counts wait cycles only; the strobe cycle itself is the extra one,
  // so ACK_TIMEOUT elapsed cycles is reached at cnt == ACK_TIMEOUT-1.
  assign expired = (cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rbcp_loc_master.sv
// rbcp_loc_master: burst initiator for the local register bus.
// Takes one command at a time, splits it into single-byte strobes at
// incrementing addresses, waits for LOC_ACK on each, streams read bytes
// out on RD_*, and closes the burst with a one-cycle DONE (ERR on timeout).
//   CLK, RSTn : clock, asynchronous active-low reset
//   bus       : rbcp_loc_master_if.master (CMD_*, WD_*, RD_*, DONE/ERR, LOC_*)
// All outputs are registered; they are derived from the next state so
// that each one lines up with the cycle the FSM spends in that state.
module rbcp_loc_master
  import rbcp_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  rbcp_loc_master_if.master     bus
);

  rbcp_state_e       state, state_nxt;

  logic              wr, wr_nxt;
  logic [LEN_W-1:0]  remain;
  logic              accept, wd_take, ack_take, tmo;
  logic              tmr_clr, tmr_en, tmr_expired;

  logic              cmd_ready, wd_ready, rd_valid, done, err;
  logic [LOC_DW-1:0] rd_data, loc_wd;
  logic [LOC_AW-1:0] loc_addr;
  logic              loc_we, loc_re;

  rbcp_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wd_take   = 1'b0;
    ack_take  = 1'b0;
    tmo       = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.CMD_VALID && cmd_ready) begin
          accept    = 1'b1;
          state_nxt = bus.CMD_WR ? ST_FETCH : ST_ISSUE;
        end
      end
      ST_FETCH: begin
        if (bus.WD_VALID && wd_ready) begin
          wd_take   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_clr   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        // An ACK arriving in the expiry cycle still wins over the timeout.
        if (bus.LOC_ACK) begin
          ack_take = 1'b1;
          if (remain == '0) begin
            state_nxt = ST_FINISH;
          end else begin
            state_nxt = wr ? ST_FETCH : ST_ISSUE;
          end
        end else if (tmr_expired) begin
          tmo       = 1'b1;
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Direction of the burst about to be (or being) executed.
  assign wr_nxt = accept ? bus.CMD_WR : wr;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr        <= 1'b0;
      remain    <= '0;
      cmd_ready <= 1'b0;
      wd_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      loc_addr  <= '0;
      loc_we    <= 1'b0;
      loc_wd    <= '0;
      loc_re    <= 1'b0;
    end else begin
      wr        <= wr_nxt;
      cmd_ready <= (state_nxt == ST_IDLE);
      wd_ready  <= (state_nxt == ST_FETCH);
      loc_we    <= (state_nxt == ST_ISSUE) &&  wr_nxt;
      loc_re    <= (state_nxt == ST_ISSUE) && !wr_nxt;
      done      <= (state_nxt == ST_FINISH);
      err       <= tmo;
      rd_valid  <= ack_take && !wr;
      if (ack_take && !wr) begin
        rd_data <= bus.LOC_RD;
      end
      if (wd_take) begin
        loc_wd <= bus.WD_DATA;
      end
      if (accept) begin
        loc_addr <= bus.CMD_ADDR;
        remain   <= bus.CMD_LEN;
      end else if (ack_take && (remain != '0)) begin
        // 32-bit address wraps naturally from all-ones to zero.
        loc_addr <= loc_addr + LOC_AW'(1);
        remain   <= remain - LEN_W'(1);
      end
    end
  end

  assign bus.CMD_READY = cmd_ready;
  assign bus.WD_READY  = wd_ready;
  assign bus.RD_VALID  = rd_valid;
  assign bus.RD_DATA   = rd_data;
  assign bus.DONE      = done;
  assign bus.ERR       = err;
  assign bus.LOC_ADDR  = loc_addr;
  assign bus.LOC_WE    = loc_we;
  assign bus.LOC_WD    = loc_wd;
  assign bus.LOC_RE    = loc_re;

endmodule

// File: tb/tb_rbcp_loc_master.sv
// Directed bench for rbcp_loc_master with a register-file responder model
// (write ACK 2 cycles after LOC_WE, read ACK 5 cycles after LOC_RE).
module tb_rbcp_loc_master;

  logic CLK;
  logic RSTn;
  int   cyc;
  int   checks;
  int   errors;

  rbcp_loc_master_if bus ();

  rbcp_loc_master #(
    .ACK_TIMEOUT(8)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- responder model ----------------
  logic [7:0]  mem [0:255];
  bit          mute;
  int          rsp_cnt;
  bit          rsp_wr;
  logic [31:0] rsp_addr;
  logic [7:0]  rsp_wd;

  always @(negedge CLK) begin
    bus.LOC_ACK = 1'b0;
    if (!RSTn) begin
      rsp_cnt = 0;
    end else begin
      if (rsp_cnt > 0) begin
        rsp_cnt = rsp_cnt - 1;
        if (rsp_cnt == 0 && !mute) begin
          bus.LOC_ACK = 1'b1;
          if (rsp_wr) mem[rsp_addr[7:0]] = rsp_wd;
          else        bus.LOC_RD = mem[rsp_addr[7:0]];
        end
      end
      if (bus.LOC_WE || bus.LOC_RE) begin
        rsp_wr   = bus.LOC_WE;
        rsp_addr = bus.LOC_ADDR;
        rsp_wd   = bus.LOC_WD;
        rsp_cnt  = bus.LOC_WE ? 2 : 5;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [31:0] re_addr_q[$];
  int          re_cyc_q[$];
  logic [31:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [7:0]  rd_q[$];
  int          done_cnt;
  int          done_cyc;
  logic        last_err;

  always @(negedge CLK) begin
    if (bus.LOC_RE) begin
      re_addr_q.push_back(bus.LOC_ADDR);
      re_cyc_q.push_back(cyc);
    end
    if (bus.LOC_WE) begin
      we_addr_q.push_back(bus.LOC_ADDR);
      we_data_q.push_back(bus.LOC_WD);
    end
    if (bus.RD_VALID) rd_q.push_back(bus.RD_DATA);
    if (bus.DONE) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      last_err = bus.ERR;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    re_addr_q.delete();
    re_cyc_q.delete();
    we_addr_q.delete();
    we_data_q.delete();
    rd_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    while (!bus.CMD_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk("cmd_ready_wait", 32'd0, 32'd1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WR    = wr;
    bus.CMD_ADDR  = addr;
    bus.CMD_LEN   = len;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] d);
    int n;
    n = 0;
    bus.WD_VALID = 1'b1;
    bus.WD_DATA  = d;
    while (!bus.WD_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk("wd_ready_wait", 32'd0, 32'd1);
    @(negedge CLK);
    bus.WD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (done_cnt == base) chk("done_wait", 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0] wdat [4];
    logic [7:0] exp_rd [4];
    int snap;
    int dbase;
    int n;
    checks = 0; errors = 0; cyc = 0; done_cnt = 0; done_cyc = 0; last_err = 1'b0;
    mute = 1'b0; rsp_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h64; mem[8'h11] = 8'h0D; mem[8'h12] = 8'h00; mem[8'h13] = 8'h00;
    bus.CMD_VALID = 1'b0; bus.CMD_WR = 1'b0; bus.CMD_ADDR = '0; bus.CMD_LEN = '0;
    bus.WD_VALID = 1'b0; bus.WD_DATA = '0; bus.LOC_ACK = 1'b0; bus.LOC_RD = '0;
    RSTn = 1'b1;
    #1 RSTn = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge CLK);
    chk("rst_cmd_ready", {31'd0, bus.CMD_READY}, 32'd0);
    chk("rst_outputs", {bus.WD_READY, bus.RD_VALID, bus.DONE, bus.ERR, bus.LOC_WE, bus.LOC_RE,
                        bus.RD_DATA, bus.LOC_WD}, 32'd0);
    chk("rst_loc_addr", bus.LOC_ADDR, 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("cmd_ready_after_rst", {31'd0, bus.CMD_READY}, 32'd1);

    // ---- read 0x10 LEN 3 ----
    clear_logs();
    do_cmd(1'b0, 32'h10, 8'd3);
    wait_done(200);
    exp_rd = '{8'h64, 8'h0D, 8'h00, 8'h00};
    chk("rd1_re_count", re_addr_q.size(), 32'd4);
    chk("rd1_rd_count", rd_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < re_addr_q.size(); i++) chk("rd1_re_addr", re_addr_q[i], 32'h10 + i);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) chk("rd1_data", {24'd0, rd_q[i]}, {24'd0, exp_rd[i]});
    chk("rd1_err", {31'd0, last_err}, 32'd0);
    if (re_cyc_q.size() >= 4) begin
      chk("rd1_re_spacing", re_cyc_q[1] - re_cyc_q[0], 32'd6);
      chk("rd1_done_latency", done_cyc - re_cyc_q[3], 32'd6);
    end
    chk("rd1_ready_again", {31'd0, bus.CMD_READY}, 32'd1);

    // ---- write 0x14 LEN 3, then read back ----
    clear_logs();
    wdat = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_cmd(1'b1, 32'h14, 8'd3);
    for (int i = 0; i < 4; i++) feed_byte(wdat[i]);
    wait_done(200);
    chk("wr_we_count", we_addr_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < we_addr_q.size(); i++) begin
      chk("wr_we_addr", we_addr_q[i], 32'h14 + i);
      chk("wr_we_data", {24'd0, we_data_q[i]}, {24'd0, wdat[i]});
    end
    chk("wr_err", {31'd0, last_err}, 32'd0);
    chk("wr_no_re", re_addr_q.size(), 32'd0);
    clear_logs();
    do_cmd(1'b0, 32'h14, 8'd3);
    wait_done(200);
    chk("rb_rd_count", rd_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) chk("rb_data", {24'd0, rd_q[i]}, {24'd0, wdat[i]});

    // ---- write with a 20-cycle WD stall before byte 2 ----
    clear_logs();
    wdat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    dbase = done_cnt;
    do_cmd(1'b1, 32'h20, 8'd3);
    feed_byte(wdat[0]);
    repeat (5) @(negedge CLK);
    snap = we_addr_q.size();
    repeat (15) @(negedge CLK);
    chk("stall_we_count", we_addr_q.size(), snap);
    chk("stall_we_one", we_addr_q.size(), 32'd1);
    chk("stall_wd_ready", {31'd0, bus.WD_READY}, 32'd1);
    chk("stall_no_done", done_cnt, dbase);
    for (int i = 1; i < 4; i++) feed_byte(wdat[i]);
    wait_done(200);
    chk("stall_we_total", we_addr_q.size(), 32'd4);
    chk("stall_err", {31'd0, last_err}, 32'd0);
    chk("stall_mem3", {24'd0, mem[8'h23]}, 32'hD4);

    // ---- ACK timeout ----
    clear_logs();
    mute = 1'b1;
    do_cmd(1'b0, 32'h1000, 8'd5);
    wait_done(100);
    chk("tmo_err", {31'd0, last_err}, 32'd1);
    if (re_cyc_q.size() >= 1) chk("tmo_latency", done_cyc - re_cyc_q[0], 32'd9);
    repeat (20) @(negedge CLK);
    chk("tmo_re_count", re_addr_q.size(), 32'd1);
    chk("tmo_re_addr", re_addr_q.size() > 0 ? re_addr_q[0] : 32'hx, 32'h1000);
    chk("tmo_no_rd", rd_q.size(), 32'd0);
    mute = 1'b0;

    // ---- address wrap ----
    clear_logs();
    do_cmd(1'b0, 32'hFFFF_FFFF, 8'd1);
    wait_done(200);
    chk("wrap_re_count", re_addr_q.size(), 32'd2);
    if (re_addr_q.size() >= 2) begin
      chk("wrap_addr0", re_addr_q[0], 32'hFFFF_FFFF);
      chk("wrap_addr1", re_addr_q[1], 32'h0000_0000);
    end
    chk("wrap_err", {31'd0, last_err}, 32'd0);

    // ---- reset during WAIT of byte 2 ----
    clear_logs();
    dbase = done_cnt;
    do_cmd(1'b0, 32'h10, 8'd3);
    n = 0;
    while (re_addr_q.size() < 2 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    chk("mid_second_re", re_addr_q.size(), 32'd2);
    repeat (2) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("mid_strobes", {30'd0, bus.LOC_RE, bus.LOC_WE}, 32'd0);
    chk("mid_outputs", {bus.CMD_READY, bus.WD_READY, bus.RD_VALID, bus.DONE, bus.ERR,
                        bus.RD_DATA}, 32'd0);
    chk("mid_loc_addr", bus.LOC_ADDR, 32'd0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    repeat (10) @(negedge CLK);
    chk("mid_no_done", done_cnt, dbase);
    chk("mid_rd_count", rd_q.size(), 32'd1);
    clear_logs();
    do_cmd(1'b0, 32'h14, 8'd1);
    wait_done(200);
    chk("post_rd_count", rd_q.size(), 32'd2);
    if (rd_q.size() >= 2) begin
      chk("post_rd0", {24'd0, rd_q[0]}, 32'h12);
      chk("post_rd1", {24'd0, rd_q[1]}, 32'h34);
    end
    chk("post_err", {31'd0, last_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=%0d", cyc, 0);
    $fatal(1);
  end

endmodule
